// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: owns the fetch PC, drives a combinational instruction
// memory, buffers fetched words in a small prefetch FIFO and hands them to
// decode over a valid/ready handshake. Redirects flush the FIFO and restart
// fetch; halt stops new fetches while the FIFO keeps draining.
// Optional feature: define INSTR_FETCH_BOUND_CHECK_EN to stop fetching and
// raise a sticky fetch_fault when the PC leaves [0, MEM_DEPTH).
module instr_fetch_ctrl #(
  parameter int                ADDR_W     = 32,
  parameter int                MEM_DEPTH  = 100,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_instr,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              fetch_fault
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

`ifdef INSTR_FETCH_BOUND_CHECK_EN
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1
  } state_t;
`endif

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   pc_reg, pc_next;
  logic [CNT_W-1:0]    count_reg, count_next;
  logic [PTR_W-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]    rd_ptr_reg, rd_ptr_next;

  logic [31:0]         data_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]   pc_mem   [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] wr_en;

  logic push;
  logic pop;
  logic in_range;
  logic has_space;

  // The memory is always addressed by the current PC; its word is captured
  // into the FIFO on the same edge that advances the PC.
  assign imem_addr = pc_reg;

  // A redirect hides the head so decode never consumes a squashed entry.
  assign inst_valid = (count_reg != '0) && !redirect_valid;

  assign inst_data = data_mem[rd_ptr_reg];
  assign inst_pc   = pc_mem[rd_ptr_reg];

  // A full FIFO can still accept a word if the head leaves the same cycle.
  assign has_space = (count_reg != FULL_COUNT) || pop;

`ifdef INSTR_FETCH_BOUND_CHECK_EN
  assign in_range    = (pc_reg < ADDR_W'(MEM_DEPTH));
  assign fetch_fault = (state_reg == ST_FAULT);
`else
  assign in_range    = 1'b1;
  assign fetch_fault = 1'b0;
`endif

  // Per-entry write strobe decoded from the tail pointer.
  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push && (wr_ptr_reg == PTR_W'(gi));
    end
  endgenerate

  // Next-state, fetch/push and pop decisions; redirect overrides everything.
  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    count_next  = count_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    push        = 1'b0;
    pop         = 1'b0;

    if (redirect_valid) begin
      pc_next     = redirect_pc;
      count_next  = '0;
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      state_next  = halt ? ST_HALT : ST_RUN;
    end else begin
      pop = inst_valid && inst_ready;
      // halt gates the fetch combinationally, so the first halted cycle
      // already issues nothing and a released halt fetches immediately.
      push = (state_reg == ST_RUN || state_reg == ST_HALT) && !halt &&
             in_range && has_space;

      case (state_reg)
        ST_RUN, ST_HALT: begin
          if (!in_range) begin
`ifdef INSTR_FETCH_BOUND_CHECK_EN
            state_next = ST_FAULT;
`endif
          end else if (halt) begin
            state_next = ST_HALT;
          end else begin
            state_next = ST_RUN;
          end
        end
        default: begin
          state_next = state_reg;
        end
      endcase

      if (push) begin
        pc_next     = pc_reg + 1'b1;
        wr_ptr_next = wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  // Control registers: state, PC, occupancy and FIFO pointers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= ST_RUN;
      pc_reg     <= RESET_PC;
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      count_reg  <= count_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  // FIFO storage; cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (wr_en[i]) begin
          data_mem[i] <= imem_instr;
          pc_mem[i]   <= pc_reg;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed testbench for instr_fetch_ctrl: reset, streaming, backpressure,
// redirect flush, halt, redirect+halt, the MEM_DEPTH boundary (with or
// without INSTR_FETCH_BOUND_CHECK_EN) and PC wrap-around.
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  instr_fetch_ctrl #(
    .ADDR_W(32), .MEM_DEPTH(100), .RESET_PC(32'd0), .FIFO_DEPTH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  // Instruction memory content: each word is its address XOR a fixed tag.
  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  assign imem_instr = word(imem_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_head(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, 32'(inst_valid), 32'd1);
    check({tag, "_pc"}, inst_pc, pc);
    check({tag, "_data"}, inst_data, word(pc));
    $display("txn %s: pc=%h data=%h", tag, inst_pc, inst_data);
  endtask

  // Advance one clock; outputs are sampled 2 time units after the edge.
  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; halt = 1'b0;
    repeat (3) tick;
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_data", inst_data, 32'd0);
    check("rst_pc", inst_pc, 32'd0);
    check("rst_fault", 32'(fetch_fault), 32'd0);
    check("rst_addr", imem_addr, 32'd0);

    // Reset release with ready high: pc 0 at head one cycle later, then 1,2,3.
    rst_n = 1'b1; inst_ready = 1'b1; #1;
    check("t1_addr", imem_addr, 32'd0);
    check("t1_valid0", 32'(inst_valid), 32'd0);
    tick; expect_head("t1_pc0", 32'd0); check("t1_addr1", imem_addr, 32'd1);
    tick; expect_head("t1_pc1", 32'd1);
    tick; expect_head("t1_pc2", 32'd2);
    tick; expect_head("t1_pc3", 32'd3);

    // Mid-operation reset discards the buffered entry.
    rst_n = 1'b0; inst_ready = 1'b0;
    tick;
    check("mrst_valid", 32'(inst_valid), 32'd0);
    check("mrst_addr", imem_addr, 32'd0);
    check("mrst_pc", inst_pc, 32'd0);

    // Backpressure: FIFO saturates at 2, PC parks at 2, head stays pc 0.
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      check("bp_pc", inst_pc, 32'd0);
      check("bp_valid", 32'(inst_valid), 32'd1);
    end
    check("bp_addr", imem_addr, 32'd2);
    inst_ready = 1'b1;
    tick; expect_head("bp_pc1", 32'd1);
    tick; expect_head("bp_pc2", 32'd2);
    tick; expect_head("bp_pc3", 32'd3);
    tick; expect_head("bp_pc4", 32'd4);
    check("bp_addr6", imem_addr, 32'd6);

    // Redirect with FIFO holding pc 4,5: both squashed, restart at 20.
    inst_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'd20; #1;
    check("rd_valid_hidden", 32'(inst_valid), 32'd0);
    tick;
    redirect_valid = 1'b0; inst_ready = 1'b1; #1;
    check("rd_addr20", imem_addr, 32'd20);
    check("rd_empty", 32'(inst_valid), 32'd0);
    tick; expect_head("rd_pc20", 32'd20);
    tick; expect_head("rd_pc21", 32'd21);
    tick; expect_head("rd_pc22", 32'd22);

    // Halt at PC=7: entries 5,6 drain, 7 is not fetched until halt drops.
    redirect_valid = 1'b1; redirect_pc = 32'd5;
    tick; redirect_valid = 1'b0;
    tick; expect_head("h_pc5", 32'd5);
    inst_ready = 1'b0;
    tick; expect_head("h_hold5", 32'd5); check("h_addr7", imem_addr, 32'd7);
    halt = 1'b1; inst_ready = 1'b1; #1;
    check("h_addr_halt", imem_addr, 32'd7);
    tick; expect_head("h_pc6", 32'd6); check("h_addr_hold1", imem_addr, 32'd7);
    tick; check("h_drained", 32'(inst_valid), 32'd0); check("h_addr_hold2", imem_addr, 32'd7);
    tick; check("h_still_empty", 32'(inst_valid), 32'd0); check("h_addr_hold3", imem_addr, 32'd7);
    halt = 1'b0;
    tick; expect_head("h_pc7", 32'd7);
    tick; expect_head("h_pc8", 32'd8);

    // Redirect and halt together: PC from redirect, state follows halt.
    redirect_valid = 1'b1; redirect_pc = 32'd40; halt = 1'b1;
    tick; redirect_valid = 1'b0; #1;
    check("rh_empty", 32'(inst_valid), 32'd0);
    check("rh_addr40", imem_addr, 32'd40);
    tick; check("rh_still_empty", 32'(inst_valid), 32'd0); check("rh_addr_hold", imem_addr, 32'd40);
    halt = 1'b0;
    tick; expect_head("rh_pc40", 32'd40);

    // MEM_DEPTH boundary at 100.
    redirect_valid = 1'b1; redirect_pc = 32'd98;
    tick; redirect_valid = 1'b0;
    tick; expect_head("bd_pc98", 32'd98);
    tick; expect_head("bd_pc99", 32'd99);
    tick;
`ifdef INSTR_FETCH_BOUND_CHECK_EN
    check("bd_no100", 32'(inst_valid), 32'd0);
    check("bd_fault", 32'(fetch_fault), 32'd1);
    check("bd_addr100", imem_addr, 32'd100);
    tick;
    check("bd_no100_b", 32'(inst_valid), 32'd0);
    check("bd_fault_sticky", 32'(fetch_fault), 32'd1);
`else
    expect_head("bd_pc100", 32'd100);
    check("bd_nofault", 32'(fetch_fault), 32'd0);
`endif
    redirect_valid = 1'b1; redirect_pc = 32'd0;
    tick; redirect_valid = 1'b0;
    check("bd_fault_clr", 32'(fetch_fault), 32'd0);
    tick; expect_head("bd_pc0", 32'd0);

`ifndef INSTR_FETCH_BOUND_CHECK_EN
    // Wrap-around: all-ones PC is followed by 0.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick; redirect_valid = 1'b0;
    tick; expect_head("wr_pcmax", 32'hFFFF_FFFF); check("wr_addr0", imem_addr, 32'd0);
    tick; expect_head("wr_pc0", 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
